// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the DMA device handshake.
// The controller side uses the same widths.
package dma_pkg;

    localparam int ADD_LEN   = 16;
    localparam int DATA_LEN  = 16;
    localparam int BUF_DEPTH = 5;
    localparam int WDOG_LEN  = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_REQ1  = 3'd2,
        ST_XFER  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } dev_state_e;

endpackage

// File: rtl/dma_dev_port_if.sv
// Device <-> DMA controller handshake bundle.
// The master modport is the device endpoint; slave is the controller.
interface dma_dev_port_if #(
    parameter int ADD_LEN  = dma_pkg::ADD_LEN,
    parameter int DATA_LEN = dma_pkg::DATA_LEN
);
    logic                rqst;
    logic                rd_wr;
    logic [ADD_LEN-1:0]  num_words;
    logic [ADD_LEN:0]    start_addr;
    logic                dev_ack;
    logic [DATA_LEN-1:0] dev_in;
    logic [DATA_LEN-1:0] dev_out;
    logic                dma_ack;
    logic                end_flag;

    modport master (
        output rqst, rd_wr, num_words, start_addr, dev_ack, dev_in,
        input  dev_out, dma_ack, end_flag
    );

    modport slave (
        input  rqst, rd_wr, num_words, start_addr, dev_ack, dev_in,
        output dev_out, dma_ack, end_flag
    );
endinterface

// File: rtl/dma_dev_buf.sv
// Local word buffer: one write port, two combinational read ports.
// Contents are deliberately not reset.
module dma_dev_buf #(
    parameter int DATA_LEN  = dma_pkg::DATA_LEN,
    parameter int BUF_DEPTH = dma_pkg::BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [BUF_DEPTH-1:0] waddr_i,
    input  logic [DATA_LEN-1:0]  wdata_i,
    input  logic [BUF_DEPTH-1:0] raddr_a_i,
    output logic [DATA_LEN-1:0]  rdata_a_o,
    input  logic [BUF_DEPTH-1:0] raddr_b_i,
    output logic [DATA_LEN-1:0]  rdata_b_o
);
    logic [DATA_LEN-1:0] mem_q [2**BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/dma_dev_port.sv
// Device-side DMA endpoint: requests a transfer, then streams words between
// the local buffer and the controller until end_flag.
//   state | meaning
//   IDLE  | waiting for cfg_start, local buffer port open
//   REQ0  | rqst, controller samples request
//   REQ1  | rqst, controller latches registers
//   XFER  | dev_ack high, words move on dma_ack
//   DRAIN | all words moved, waiting for end_flag
//   FIN   | done pulse
//   ERR   | error pulse (bad length or watchdog)
module dma_dev_port #(
    parameter int ADD_LEN   = dma_pkg::ADD_LEN,
    parameter int DATA_LEN  = dma_pkg::DATA_LEN,
    parameter int BUF_DEPTH = dma_pkg::BUF_DEPTH,
    parameter int WDOG_LEN  = dma_pkg::WDOG_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_dir,
    input  logic [BUF_DEPTH:0]   cfg_len,
    input  logic [ADD_LEN-1:0]   cfg_addr,
    input  logic                 loc_we,
    input  logic [BUF_DEPTH-1:0] loc_addr,
    input  logic [DATA_LEN-1:0]  loc_wdata,
    output logic [DATA_LEN-1:0]  loc_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [BUF_DEPTH:0]   words_moved,
    dma_dev_port_if.master       dma
);
    import dma_pkg::*;

    localparam logic [BUF_DEPTH:0] LEN_MAX = (BUF_DEPTH+1)'(2**BUF_DEPTH);

    dev_state_e           state_q, state_d;
    logic [BUF_DEPTH-1:0] ptr_q, ptr_d;
    logic [BUF_DEPTH:0]   words_q, words_d;
    logic [BUF_DEPTH:0]   len_q, len_d;
    logic [BUF_DEPTH:0]   words_inc;
    logic [WDOG_LEN-1:0]  wdog_q, wdog_d;
    logic                 dir_q, dir_d;
    logic [ADD_LEN-1:0]   addr_q, addr_d;
    logic                 accept;
    logic                 buf_we;
    logic [BUF_DEPTH-1:0] buf_waddr;
    logic [DATA_LEN-1:0]  buf_wdata;
    logic [DATA_LEN-1:0]  buf_rd_b;

    // A dma_ack once the count is complete is not a transfer.
    assign accept    = (state_q == ST_XFER) && dma.dma_ack && (words_q != len_q);
    assign words_inc = words_q + (BUF_DEPTH+1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            words_q <= '0;
            len_q   <= '0;
            wdog_q  <= '1;
            dir_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            len_q   <= len_d;
            wdog_q  <= wdog_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        words_d   = words_q;
        len_d     = len_q;
        wdog_d    = wdog_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        buf_we    = 1'b0;
        buf_waddr = loc_addr;
        buf_wdata = loc_wdata;
        case (state_q)
            ST_IDLE: begin
                buf_we = loc_we;
                if (cfg_start) begin
                    dir_d   = cfg_dir;
                    len_d   = cfg_len;
                    addr_d  = cfg_addr;
                    ptr_d   = '0;
                    words_d = '0;
                    wdog_d  = '1;
                    state_d = (cfg_len > LEN_MAX) ? ST_ERR : ST_REQ0;
                end
            end
            ST_REQ0: state_d = ST_REQ1;
            // zero-length transfers never raise dev_ack
            ST_REQ1: state_d = (len_q == '0) ? ST_DRAIN : ST_XFER;
            ST_XFER, ST_DRAIN: begin
                if (accept) begin
                    ptr_d   = ptr_q + BUF_DEPTH'(1);
                    words_d = words_inc;
                    if (dir_q) begin
                        buf_we    = 1'b1;
                        buf_waddr = ptr_q;
                        buf_wdata = dma.dev_out;
                    end
                    if (words_inc == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (dma.dma_ack || dma.end_flag) begin
                    wdog_d = '1;
                end else if (wdog_q == '0) begin
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q - WDOG_LEN'(1);
                end
            end
            ST_FIN, ST_ERR: state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        if (dma.end_flag && (state_q inside {ST_REQ0, ST_REQ1, ST_XFER, ST_DRAIN})) begin
            state_d = ST_FIN;
        end
    end

    dma_dev_buf #(
        .DATA_LEN (DATA_LEN),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .we_i     (buf_we),
        .waddr_i  (buf_waddr),
        .wdata_i  (buf_wdata),
        .raddr_a_i(loc_addr),
        .rdata_a_o(loc_rdata),
        .raddr_b_i(ptr_q),
        .rdata_b_o(buf_rd_b)
    );

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign error          = (state_q == ST_ERR);
    assign words_moved    = words_q;
    assign dma.rqst       = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign dma.dev_ack    = (state_q == ST_XFER);
    assign dma.rd_wr      = dir_q;
    assign dma.num_words  = ADD_LEN'(len_q);
    assign dma.start_addr = {1'b0, addr_q};
    assign dma.dev_in     = ((state_q == ST_XFER) && !dir_q) ? buf_rd_b : '0;
endmodule

// File: tb/tb_dma_dev_port.sv
// Scoreboard bench for dma_dev_port with a simple controller model.
module tb_dma_dev_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start, cfg_dir, loc_we;
    logic [5:0]  cfg_len;
    logic [15:0] cfg_addr;
    logic [4:0]  loc_addr;
    logic [15:0] loc_wdata, loc_rdata;
    logic        busy, done, error;
    logic [5:0]  words_moved;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    dma_dev_port_if #(.ADD_LEN(16), .DATA_LEN(16)) dif ();

    dma_dev_port dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_dir    (cfg_dir),
        .cfg_len    (cfg_len),
        .cfg_addr   (cfg_addr),
        .loc_we     (loc_we),
        .loc_addr   (loc_addr),
        .loc_wdata  (loc_wdata),
        .loc_rdata  (loc_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_moved(words_moved),
        .dma        (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [15:0] d);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        tick();
        loc_we = 1'b0;
    endtask

    task automatic start(input logic dir, input logic [5:0] len, input logic [15:0] addr);
        cfg_start = 1'b1; cfg_dir = dir; cfg_len = len; cfg_addr = addr;
        tick();
        cfg_start = 1'b0;
    endtask

    // Controller model: acks while dev_ack is up, skipping every gap-th cycle.
    task automatic run_xfer(input int n, input int gap, input bit is_read);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < 500) begin
            dif.dma_ack = 1'b0;
            if (dif.dev_ack && !(gap != 0 && (cyc % gap) == gap - 1)) begin
                dif.dma_ack = 1'b1;
                if (is_read) begin
                    dif.dev_out = 16'($urandom);
                    exp_q.push_back(dif.dev_out);
                end else if (exp_q.size() == 0) begin
                    chk("wr_extra_word", 32'(dif.dev_in), 32'hFFFF_FFFF);
                end else begin
                    chk("wr_data", 32'(dif.dev_in), 32'(exp_q.pop_front()));
                end
                cnt++;
            end
            tick();
            cyc++;
        end
        dif.dma_ack = 1'b0;
        chk("xfer_count", 32'(cnt), 32'(n));
    endtask

    task automatic finish_xfer(input int exp_words);
        dif.end_flag = 1'b1;
        tick();
        dif.end_flag = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("words_moved", 32'(words_moved), 32'(exp_words));
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        int cyc;
        reset = 1'b1; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_len = '0; cfg_addr = '0;
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        dif.dev_out = '0; dif.dma_ack = 1'b0; dif.end_flag = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_rqst", 32'(dif.rqst), 32'd0);
        chk("rst_dev_ack", 32'(dif.dev_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, error}), 32'd0);
        chk("rst_regs", 32'({dif.rd_wr, dif.num_words}), 32'd0);
        chk("rst_addr", 32'(dif.start_addr), 32'd0);
        chk("rst_words", 32'(words_moved), 32'd0);

        // write 4 words to memory
        for (int i = 0; i < 4; i++) begin
            loc_write(5'(i), 16'(16'hA0 + i));
            exp_q.push_back(16'(16'hA0 + i));
        end
        start(1'b0, 6'd4, 16'h0200);
        chk("w_rqst0", 32'(dif.rqst), 32'd1);
        chk("w_busy", 32'(busy), 32'd1);
        chk("w_num_words", 32'(dif.num_words), 32'd4);
        chk("w_start_addr", 32'(dif.start_addr), 32'h0200);
        chk("w_rd_wr", 32'(dif.rd_wr), 32'd0);
        tick();
        chk("w_rqst1", 32'(dif.rqst), 32'd1);
        tick();
        chk("w_rqst_off", 32'(dif.rqst), 32'd0);
        run_xfer(4, 0, 1'b0);
        chk("w_drain", 32'(dif.dev_ack), 32'd0);
        chk("w_q_empty", 32'(exp_q.size()), 32'd0);
        dif.dma_ack = 1'b1;
        tick();
        dif.dma_ack = 1'b0;
        chk("w_late_ack", 32'(words_moved), 32'd4);
        finish_xfer(4);

        // read 32 words with gaps; pointer wraps at the end
        start(1'b1, 6'd32, 16'h1000);
        tick(); tick();
        run_xfer(32, 3, 1'b1);
        chk("r_drain", 32'(dif.dev_ack), 32'd0);
        finish_xfer(32);
        for (int i = 0; i < 32; i++) begin
            loc_addr = 5'(i);
            #1;
            chk("r_buf", 32'(loc_rdata), 32'(exp_q.pop_front()));
        end

        // zero-length transfer
        start(1'b1, 6'd0, 16'h0010);
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            chk("z_rqst", 32'(dif.rqst), 32'd1);
            cnt += int'(dif.dev_ack);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            cnt += int'(dif.dev_ack);
            tick();
        end
        chk("z_no_dev_ack", 32'(cnt), 32'd0);
        finish_xfer(0);

        // bad length
        start(1'b0, 6'd33, 16'h0020);
        chk("bl_error", 32'(error), 32'd1);
        chk("bl_no_rqst", 32'(dif.rqst), 32'd0);
        tick();
        chk("bl_error_clear", 32'(error), 32'd0);
        chk("bl_idle", 32'(busy), 32'd0);

        // watchdog: controller never acks
        start(1'b1, 6'd4, 16'h0040);
        tick(); tick();
        cnt = 0; cyc = 0;
        while (!error && cyc < 1100) begin
            cnt += int'(dif.dev_ack);
            tick();
            cyc++;
        end
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_cycles", 32'(cnt), 32'd1024);
        tick();
        chk("wd_idle", 32'(busy), 32'd0);
        loc_write(5'd0, 16'h5A5A);
        exp_q.push_back(16'h5A5A);
        start(1'b0, 6'd1, 16'h0300);
        chk("wd_restart", 32'(dif.rqst), 32'd1);
        tick(); tick();
        run_xfer(1, 0, 1'b0);
        finish_xfer(1);

        // reset in the middle of a read
        start(1'b1, 6'd10, 16'h0400);
        tick(); tick();
        run_xfer(5, 0, 1'b1);
        exp_q.delete();
        chk("mr_words_pre", 32'(words_moved), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_ctrl", 32'({dif.rqst, dif.dev_ack, busy, done, error, dif.rd_wr}), 32'd0);
        chk("mr_regs", 32'({dif.num_words, dif.start_addr}), 32'd0);
        chk("mr_words", 32'(words_moved), 32'd0);
        chk("mr_dev_in", 32'(dif.dev_in), 32'd0);
        dif.end_flag = 1'b1;
        tick();
        dif.end_flag = 1'b0;
        chk("mr_no_done", 32'(done), 32'd0);
        tick();
        chk("mr_no_done2", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
